prod_accum: RTL and testbench
=============================

# prod_accum

Sequential accumulator placed directly downstream of the combinational 8x8 multiplier. It takes the 16-bit unsigned product stream, sums LEN consecutive accepted products into one frame total, and presents that total with a valid/ready handshake. If the sum exceeds the accumulator width, the total saturates and a flag is raised. It is the first registered stage after the multiplier and provides the datapath's frame-level result.

## Interface
- LEN, default 4: products per frame; legal range 1..255.
- ACC_W, default 17: accumulator/output width; legal range 16..24. Saturation is possible whenever ACC_W < 16 + clog2(LEN).

- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- clr  input  1  synchronous abort; discards the partial frame and any held result.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  16  unsigned product from the multiplier.
- out_valid  output  1  out_sum and out_sat hold a completed frame.
- out_ready  input  1  consumer accepts the result this cycle.
- out_sum  output  ACC_W  unsigned frame total, saturated.
- out_sat  output  1  frame total was clamped.
- busy  output  1  a frame is in progress or held (state != IDLE).

## Operation
- An input is accepted when in_valid && in_ready. An output is taken when out_valid && out_ready.
- The FSM has three states: IDLE, ACC, HOLD.
- **IDLE:** in_ready=1.
  - On accept: acc <= in_data, cnt <= 1, sat <= 0.
  - Next state is ACC, or HOLD if LEN==1.
- **ACC:** in_ready=1.
  - On accept: acc <= sat_add(acc, in_data), cnt <= cnt+1.
  - When the accepted word is the LEN-th, go to HOLD.
  - Cycles without in_valid leave all state unchanged; gaps are allowed.
- **HOLD:** in_ready=0, out_valid=1.
  - out_sum=acc and out_sat=sat; both stay stable until out_ready is seen.
  - On out_ready: go to IDLE.
- **Arithmetic:**
  - The sum is computed at ACC_W+1 bits.
  - If the result exceeds 2^ACC_W-1, acc <= 2^ACC_W-1 and sat <= 1.
  - sat is sticky for the rest of the frame. Once saturated, acc stays at max.
- **clr:** from any state, the next state is IDLE with acc=0, cnt=0, sat=0 and out_valid=0.
  - clr beats a simultaneous input accept; the word is dropped.
  - clr beats a simultaneous output handshake; the result is discarded.
- **rst_n low:** immediate return to IDLE regardless of clk.
  - Reset values: acc=0, cnt=0, sat=0, out_valid=0, out_sum=0, out_sat=0, busy=0, in_ready=1.
  - A reset mid-frame loses the partial sum.
- out_sum and out_sat are driven from registers. They show 0 whenever out_valid=0.

## Timing
- Latency: out_valid rises on the clock edge that accepts the LEN-th word, so it is visible in the next cycle.
- Minimum frame period is LEN+1 cycles: LEN accept cycles plus at least one HOLD cycle. in_ready is low throughout HOLD.
- After the HOLD handshake, in_ready=1 in the following cycle. No combinational path exists from out_ready to in_ready.
- No combinational path exists from in_valid or in_data to any output. in_ready depends only on state.
- With out_ready held high, HOLD lasts exactly 1 cycle.
- Under backpressure, HOLD lasts an unbounded number of cycles with outputs frozen.
- cnt is ceil(log2(LEN+1)) bits wide. It never wraps, because it resets to 0/1 at each frame start.

## Test plan
All scenarios use default parameters (LEN=4, ACC_W=17).
- **Basic frame:** send 10, 20, 30, 40 back-to-back with out_ready=1. Required: out_valid=1 for exactly one cycle, starting the cycle after the 4th accept, with out_sum=100 and out_sat=0; in_ready=0 during that cycle.
- **Saturation:** send 65025 four times. Required: out_sum=131071, out_sat=1. The next frame of 1, 1, 1, 1 gives out_sum=4, out_sat=0 (sticky flag cleared).
- **Backpressure:** hold out_ready=0 for 5 cycles after completing the frame 1, 2, 3, 4. Required: out_valid=1, out_sum=10 and in_ready=0, all stable for 5 cycles. Then raise out_ready for one cycle: out_valid=0 and in_ready=1 in the next cycle.
- **Input gaps:** send 5, idle 3 cycles, 5, idle, 5, 5. Required: out_sum=20; cnt is unaffected by idle cycles.
- **clr mid-frame:** after accepting 7 and 8, assert clr together with in_valid on data 9. Required: 9 is dropped and busy=0 next cycle. A following frame of 1, 1, 1, 1 gives out_sum=4.
- **Async reset:** pull rst_n low mid-cycle, between clock edges, in ACC after 2 words. Required: busy=0, out_valid=0, out_sum=0 and in_ready=1 without waiting for a clock edge. After release, a frame of 2, 2, 2, 2 gives out_sum=8.

Source files
------------

// File: rtl/prod_accum.sv
// prod_accum: sums LEN consecutive 16-bit products into one saturating
// frame total and presents it on a valid/ready output port.
module prod_accum #(
  parameter int LEN   = 4,
  parameter int ACC_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat,
  output logic             busy
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam int AW1   = ACC_W + 1;
  localparam logic [ACC_W-1:0] MAX = '1;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state, nxt;
  logic [ACC_W-1:0] acc, sum_q, nacc;
  logic [CNT_W-1:0] cnt;
  logic             sat, sat_q, nsat;
  logic [ACC_W:0]   add_full;
  logic             accept, take, last;

  // in_ready and out_valid depend on state only, so neither out_ready nor
  // in_valid/in_data has a combinational path to any output.
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign out_sum   = sum_q;
  assign out_sat   = sat_q;
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  // Next accumulator value: first word of a frame loads, later words add
  // one bit wider and clamp to all-ones on carry-out (flag is sticky).
  always_comb begin
    add_full = {1'b0, acc} + AW1'(in_data);
    last     = (state == IDLE) ? (LEN == 1) : (cnt == CNT_W'(LEN - 1));
    if (state == IDLE) begin
      nacc = ACC_W'(in_data);
      nsat = 1'b0;
    end else begin
      nacc = add_full[ACC_W] ? MAX : add_full[ACC_W-1:0];
      nsat = sat | add_full[ACC_W];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic; clr overrides every transition.
  always_comb begin
    nxt = state;
    case (state)
      IDLE, ACC: if (accept) nxt = last ? HOLD : ACC;
      HOLD:      if (out_ready) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    if (clr) nxt = IDLE;
  end

  // Datapath: accumulator, word count and the registered result, which is
  // loaded on the last accept and zeroed once the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
      sum_q <= '0;
      sat_q <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
      sum_q <= '0;
      sat_q <= 1'b0;
    end else begin
      if (accept) begin
        acc <= nacc;
        sat <= nsat;
        cnt <= (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
        if (last) begin
          sum_q <= nacc;
          sat_q <= nsat;
        end
      end
      if (take) begin
        sum_q <= '0;
        sat_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum (LEN=4, ACC_W=17): stimulus pushes the
// hand-computed frame result, a monitor pops and compares on each handshake.
module tb_prod_accum;
  localparam int LEN   = 4;
  localparam int ACC_W = 17;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic             out_sat;
  logic             busy;

  int tests = 0;
  int fails = 0;
  logic [ACC_W:0] sb[$];   // {sat, sum}

  prod_accum #(.LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_frame(input int sum, input bit s);
    sb.push_back({s, ACC_W'(sum)});
  endtask

  // Drive one word; waits (bounded) until in_ready is seen at the edge.
  task automatic send(input int d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'(d);
    for (int i = 0; i < 20; i++) begin
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Monitor: compare every taken result against the scoreboard, and check
  // the outputs read zero whenever no result is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          logic [ACC_W:0] e;
          e = sb.pop_front();
          chk("out_sum", int'(out_sum), int'(e[ACC_W-1:0]));
          chk("out_sat", int'(out_sat), int'(e[ACC_W]));
        end
      end else if (!out_valid) begin
        chk("idle_out_zero", int'({out_sat, out_sum}), 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end by 100000");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame: exactly one HOLD cycle with out_ready high
    expect_frame(100, 0);
    send(10); send(20); send(30); send(40);
    chk("basic_out_valid", out_valid, 1);
    chk("basic_in_ready_hold", in_ready, 0);
    @(posedge clk); #1;
    chk("basic_valid_one_cycle", out_valid, 0);
    chk("basic_in_ready_after", in_ready, 1);

    // Saturation, then flag cleared on next frame
    expect_frame(131071, 1);
    repeat (4) send(65025);
    expect_frame(4, 0);
    repeat (4) send(1);
    @(posedge clk); #1;

    // Backpressure
    out_ready = 1'b0;
    expect_frame(10, 0);
    send(1); send(2); send(3); send(4);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_sum", int'(out_sum), 10);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);

    // Input gaps
    expect_frame(20, 0);
    send(5);
    repeat (3) @(posedge clk);
    #1;
    chk("gap_busy", busy, 1);
    send(5);
    @(posedge clk); #1;
    send(5); send(5);
    @(posedge clk); #1;

    // clr mid-frame beats a simultaneous accept
    send(7); send(8);
    in_valid = 1'b1; in_data = 16'd9; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_out_valid", out_valid, 0);
    expect_frame(4, 0);
    repeat (4) send(1);
    @(posedge clk); #1;

    // Async reset mid-cycle while in ACC
    send(3); send(3);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_sum", int'(out_sum), 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    expect_frame(8, 0);
    repeat (4) send(2);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
